gs_if_stage: RTL and testbench

//  Instruction fetch stage. Owns the fetch PC, issues word fetches on a req/gnt/rvalid

---
 rtl/gs_if_stage.sv | 130 +++++++++++++
 tb/tb_gs_if_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_if_stage.sv
// rtl/gs_if_stage.sv - instruction fetch stage: one outstanding imem fetch feeding a small head-registered FIFO
module gs_if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_if_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_4_o,
  output logic [31:0] instr_o,
  output logic        if_valid_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {RST_S, REQ_S, WAIT_S, KILL_S} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pc_mem_q    [FIFO_DEPTH];
  logic [31:0]      pc_mem_d    [FIFO_DEPTH];
  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [31:0]      instr_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             grant;
  logic             push;
  logic             pop;

  assign if_valid_o = (count_q != '0);
  assign pc_o       = pc_mem_q[rd_ptr_q];
  assign pc_4_o     = pc_mem_q[rd_ptr_q] + 32'd4;
  assign instr_o    = instr_mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    imem_req_o  = 1'b0;
    imem_addr_o = fetch_pc_q;
    grant       = 1'b0;
    push        = 1'b0;
    pop         = if_valid_o & ~halt_if_i & ~redirect_i;

    // The in-flight slot is only taken when the FIFO can still absorb its response.
    case (state_q)
      RST_S: state_d = REQ_S;
      REQ_S: begin
        imem_req_o = (count_q < DEPTH_C);
        grant      = imem_req_o & imem_gnt_i;
        if (grant) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT_S;
        end
      end
      WAIT_S: begin
        if (imem_rvalid_i) begin
          push    = ~redirect_i;
          state_d = REQ_S;
        end
      end
      KILL_S: begin
        if (imem_rvalid_i) state_d = REQ_S;
      end
      default: state_d = RST_S;
    endcase

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // A fetch still owed by memory must be swallowed before refetching.
      if (grant || (state_q == WAIT_S && !imem_rvalid_i) ||
          (state_q == KILL_S && !imem_rvalid_i)) begin
        state_d = KILL_S;
      end else begin
        state_d = REQ_S;
      end
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q - 32'd4;
        instr_mem_d[wr_ptr_q] = imem_rdata_i;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_S;
      fetch_pc_q  <= RESET_PC;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_gs_if_stage.sv
// tb/tb_gs_if_stage.sv - randomized scoreboard bench for gs_if_stage
module tb_gs_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_if_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_4_o;
  logic [31:0] instr_o;
  logic        if_valid_o;

  always #5 clk = ~clk;

  gs_if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_if_i(halt_if_i),
    .pc_o(pc_o), .pc_4_o(pc_4_o), .instr_o(instr_o), .if_valid_o(if_valid_o)
  );

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Expected decode stream: consecutive words from the latest reset/redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] next_push;

  task automatic sb_topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_push);
      next_push = next_push + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] tgt);
    exp_q.delete();
    next_push = tgt;
    sb_topup();
  endtask

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } mrsp_t;
  mrsp_t mq[$];

  int unsigned cyc = 0;
  bit          gnt_always = 1'b1;
  bit          gnt_off = 1'b0;
  int unsigned dmin = 1, dmax = 1;
  int unsigned halt_pct = 0, redir_pct = 0;
  bit          force_halt = 1'b0, force_redir = 1'b0;
  bit          redir_on_gnt = 1'b0, redir_on_rv = 1'b0, stale_rv = 1'b0;
  logic [31:0] force_tgt = '0;

  task automatic step();
    bit          g;
    bit          rd;
    logic [31:0] tgt;
    mrsp_t       r;
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (stale_rv) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      stale_rv      = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mq[0].data;
      void'(mq.pop_front());
    end
    g = !gnt_off && !rst && imem_req_o && (gnt_always || $urandom_range(0, 99) < 60);
    imem_gnt_i = g;
    if (g) begin
      check32("one_outstanding", 32'(mq.size()), 32'd0);
      r.due  = cyc + $urandom_range(dmin, dmax);
      r.data = imem_addr_o ^ KEY;
      mq.push_back(r);
    end
    halt_if_i = force_halt || ($urandom_range(0, 99) < halt_pct);
    rd = force_redir || (redir_on_gnt && g) || (redir_on_rv && imem_rvalid_i) ||
         ($urandom_range(0, 99) < redir_pct);
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    if (rd && !rst) begin
      if (force_redir) tgt = force_tgt;
      else if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else tgt = $urandom;
      force_redir   = 1'b0;
      redir_on_gnt  = 1'b0;
      redir_on_rv   = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = tgt;
      sb_restart({tgt[31:2], 2'b00});
    end
    sb_topup();
  endtask

  task automatic step_until_grant(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!imem_gnt_i && n < 50);
    check1(name, imem_gnt_i, 1'b1);
  endtask

  // Monitor: compares every accepted head against the scoreboard and every grant address.
  initial begin : monitor
    logic [31:0] exp_addr, prev_pc, prev_instr, e;
    bit prev_hold, post_redir;
    exp_addr = RST_PC;
    prev_pc = '0;
    prev_instr = '0;
    prev_hold = 1'b0;
    post_redir = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_addr   = RST_PC;
        prev_hold  = 1'b0;
        post_redir = 1'b0;
      end else begin
        if (post_redir) check1("valid_after_redirect", if_valid_o, 1'b0);
        if (prev_hold) begin
          check1("hold_valid", if_valid_o, 1'b1);
          check32("hold_pc", pc_o, prev_pc);
          check32("hold_instr", instr_o, prev_instr);
        end
        if (imem_req_o && imem_gnt_i) begin
          check32("fetch_addr", imem_addr_o, exp_addr);
          exp_addr = exp_addr + 32'd4;
        end
        if (redirect_i) exp_addr = {redirect_pc_i[31:2], 2'b00};
        if (if_valid_o && !halt_if_i && !redirect_i) begin
          pops++;
          if (exp_q.size() == 0) begin
            check1("scoreboard_nonempty", 1'b0, 1'b1);
          end else begin
            e = exp_q.pop_front();
            check32("pc", pc_o, e);
            check32("pc_4", pc_4_o, e + 32'd4);
            check32("instr", instr_o, e ^ KEY);
          end
        end
        prev_hold  = if_valid_o && halt_if_i && !redirect_i;
        prev_pc    = pc_o;
        prev_instr = instr_o;
        post_redir = redirect_i;
      end
    end
  end

  initial begin : driver
    int p0;
    sb_restart(RST_PC);
    repeat (3) @(posedge clk);
    #1;
    check1("rst_req", imem_req_o, 1'b0);
    check32("rst_addr", imem_addr_o, RST_PC);
    check1("rst_valid", if_valid_o, 1'b0);
    check32("rst_pc", pc_o, 32'h0);
    check32("rst_pc_4", pc_4_o, 32'h4);
    check32("rst_instr", instr_o, 32'h0);
    rst = 1'b0;

    step();
    check1("first_valid_c1", if_valid_o, 1'b0);
    step();
    check1("first_valid_c2", if_valid_o, 1'b0);
    step();
    check1("first_valid_c3", if_valid_o, 1'b1);
    check32("first_pc", pc_o, RST_PC);
    repeat (12) step();

    force_halt = 1'b1;
    repeat (10) step();
    check1("halt_full_valid", if_valid_o, 1'b1);
    check1("halt_full_req", imem_req_o, 1'b0);
    force_halt = 1'b0;
    repeat (20) step();

    dmin = 3;
    dmax = 3;
    step_until_grant("grant_before_wait_redirect");
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0103;
    step();
    step();
    check1("wait_redirect_valid_low", if_valid_o, 1'b0);
    step_until_grant("refetch_grant");
    check32("refetch_addr", imem_addr_o, 32'h0000_0100);
    repeat (12) step();

    dmin = 1;
    dmax = 1;
    redir_on_gnt = 1'b1;
    step_until_grant("grant_with_redirect");
    repeat (10) step();
    redir_on_rv = 1'b1;
    for (int i = 0; i < 50 && redir_on_rv; i++) step();
    check1("rvalid_redirect_taken", redir_on_rv, 1'b0);
    repeat (10) step();

    dmin = 3;
    dmax = 3;
    step_until_grant("grant_before_reset");
    step();
    rst = 1'b1;
    mq.delete();
    sb_restart(RST_PC);
    #1;
    check1("midrst_req", imem_req_o, 1'b0);
    check1("midrst_valid", if_valid_o, 1'b0);
    check32("midrst_addr", imem_addr_o, RST_PC);
    check32("midrst_pc", pc_o, 32'h0);
    step();
    step();
    rst = 1'b0;
    gnt_off = 1'b1;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    stale_rv = 1'b1;
    step();
    step();
    check1("stale_rvalid_ignored", if_valid_o, 1'b0);
    gnt_off = 1'b0;
    dmin = 1;
    dmax = 1;
    step_until_grant("restart_grant");
    check32("restart_addr", imem_addr_o, RST_PC);
    repeat (10) step();

    p0 = pops;
    gnt_always = 1'b0;
    dmin = 1;
    dmax = 3;
    halt_pct = 30;
    redir_pct = 4;
    repeat (3000) step();
    check1("random_progress", (pops - p0) >= 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
